// File: rtl/invader_bombs_if.sv
// Bus between the invader_bombs stage and its neighbours: formation/player state in,
// bomb slots and the player-hit pulse out.
interface invader_bombs_if #(
  parameter int NUM_BOMBS = 3
);
  logic                     frame;
  logic [54:0]              invaders;
  logic [9:0]               invaders_x;
  logic [9:0]               invaders_y;
  logic [9:0]               player_x;
  logic [9:0]               player_y;
  logic [NUM_BOMBS-1:0]     bomb_active;
  logic [10*NUM_BOMBS-1:0]  bomb_x;
  logic [10*NUM_BOMBS-1:0]  bomb_y;
  logic                     player_collision;

  modport master (
    output frame, invaders, invaders_x, invaders_y, player_x, player_y,
    input  bomb_active, bomb_x, bomb_y, player_collision
  );

  modport slave (
    input  frame, invaders, invaders_x, invaders_y, player_x, player_y,
    output bomb_active, bomb_x, bomb_y, player_collision
  );
endinterface

// File: rtl/invader_bombs.sv
// Invader bomb spawner/mover with player hit detection.
// Optional macro BOMB_AIM_EN: aim the start column at the player instead of using the LFSR.
module invader_bombs #(
  parameter int NUM_BOMBS   = 3,
  parameter int FIRE_PERIOD = 40,
  parameter int BOMB_SPEED  = 4,
  parameter int COL_PITCH   = 32,
  parameter int ROW_PITCH   = 24,
  parameter int INV_W       = 24,
  parameter int INV_H       = 16,
  parameter int PLAYER_W    = 26,
  parameter int PLAYER_H    = 16,
  parameter int BOMB_W      = 2,
  parameter int BOMB_H      = 8,
  parameter int SCREEN_H    = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arst,
  invader_bombs_if.slave bus
);
  localparam int         FCW     = $clog2(FIRE_PERIOD + 1);
  localparam logic [9:0] Y_LIMIT = 10'(SCREEN_H - BOMB_H);

  typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_t;

  state_t               state_r, state_s;
  logic [3:0]           col_r, col_s;
  logic [3:0]           scan_cnt_r, scan_cnt_s;
  logic [7:0]           lfsr_r;
  logic [FCW-1:0]       fire_cnt_r;
  logic [NUM_BOMBS-1:0] bomb_active_r, active_s;
  logic [9:0]           bomb_x_r [NUM_BOMBS];
  logic [9:0]           bomb_y_r [NUM_BOMBS];
  logic [9:0]           x_next_s [NUM_BOMBS];
  logic [9:0]           y_next_s [NUM_BOMBS];
  logic [9:0]           y_mv_s   [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] ovl_s;
  logic                 collision_r, hit_s, placed_s;
  logic                 fire_s, spawn_req_s;
  logic [3:0]           start_col_s;
  logic [4:0]           col_bits_s;
  logic [2:0]           row_s;
  logic [9:0]           spawn_x_s, spawn_y_s;

  assign fire_s = bus.frame && (fire_cnt_r == '0);

`ifdef BOMB_AIM_EN
  logic [10:0] centre_s, diff_s, quot_s;
  // Start column under the player's centre, clamped to the formation
  always_comb begin
    centre_s    = {1'b0, bus.player_x} + 11'(PLAYER_W / 2);
    diff_s      = centre_s - {1'b0, bus.invaders_x};
    quot_s      = diff_s / 11'(COL_PITCH);
    if (centre_s < {1'b0, bus.invaders_x}) begin
      start_col_s = 4'd0;
    end else if (quot_s > 11'd10) begin
      start_col_s = 4'd10;
    end else begin
      start_col_s = quot_s[3:0];
    end
  end
`else
  // Random start column folded into 0..10
  always_comb begin
    if (lfsr_r[3:0] < 4'd11) begin
      start_col_s = lfsr_r[3:0];
    end else begin
      start_col_s = lfsr_r[3:0] - 4'd11;
    end
  end
`endif

  // Alive bits of the current column and its lowest (highest-numbered) alive row
  always_comb begin
    col_bits_s = 5'd0;
    row_s      = 3'd0;
    if (col_r <= 4'd10) begin
      for (int r = 0; r < 5; r++) begin
        col_bits_s[r] = bus.invaders[r * 11 + int'(col_r)];
      end
    end else begin
      col_bits_s = 5'd0;
    end
    for (int r = 0; r < 5; r++) begin
      row_s = col_bits_s[r] ? 3'(r) : row_s;
    end
    spawn_x_s = bus.invaders_x + 10'(int'(col_r) * COL_PITCH) + 10'(INV_W / 2 - 1);
    spawn_y_s = bus.invaders_y + 10'(int'(row_s) * ROW_PITCH) + 10'(INV_H);
  end

  // Fire FSM: scan columns from the start column until one has a live invader
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    scan_cnt_s  = scan_cnt_r;
    spawn_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s    = SCAN;
          col_s      = start_col_s;
          scan_cnt_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (|col_bits_s) begin
          state_s = SPAWN;
        end else if (scan_cnt_r == 4'd10) begin
          state_s = IDLE;
        end else begin
          col_s      = (col_r == 4'd10) ? 4'd0 : col_r + 4'd1;
          scan_cnt_s = scan_cnt_r + 4'd1;
        end
      end
      SPAWN: begin
        spawn_req_s = 1'b1;
        state_s     = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Candidate position one frame later and its strict overlap with the player
  always_comb begin
    for (int i = 0; i < NUM_BOMBS; i++) begin
      y_mv_s[i] = bomb_y_r[i] + 10'(BOMB_SPEED);
      ovl_s[i]  = ({1'b0, bomb_x_r[i]} < {1'b0, bus.player_x} + 11'(PLAYER_W)) &&
                  ({1'b0, bus.player_x} < {1'b0, bomb_x_r[i]} + 11'(BOMB_W)) &&
                  ({1'b0, y_mv_s[i]}    < {1'b0, bus.player_y} + 11'(PLAYER_H)) &&
                  ({1'b0, bus.player_y} < {1'b0, y_mv_s[i]} + 11'(BOMB_H));
    end
  end

  // Slot update: move on frame, then spawn into the lowest slot free after the move
  always_comb begin
    active_s = bomb_active_r;
    hit_s    = 1'b0;
    placed_s = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      x_next_s[i] = bomb_x_r[i];
      y_next_s[i] = bomb_y_r[i];
    end
    if (bus.frame) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        if (!bomb_active_r[i]) begin
          active_s[i] = 1'b0;
        end else if (y_mv_s[i] > Y_LIMIT) begin
          active_s[i] = 1'b0;
        end else if (ovl_s[i]) begin
          active_s[i] = 1'b0;
          hit_s       = 1'b1;
        end else begin
          y_next_s[i] = y_mv_s[i];
        end
      end
    end else begin
      hit_s = 1'b0;
    end
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (spawn_req_s && !placed_s && !active_s[i]) begin
        active_s[i] = 1'b1;
        x_next_s[i] = spawn_x_s;
        y_next_s[i] = spawn_y_s;
        placed_s    = 1'b1;
      end else begin
        placed_s = placed_s;
      end
    end
  end

  // State registers; arst is a synchronous restart identical to rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      col_r         <= 4'd0;
      scan_cnt_r    <= 4'd0;
      lfsr_r        <= 8'hA5;
      fire_cnt_r    <= FCW'(FIRE_PERIOD - 1);
      bomb_active_r <= '0;
      collision_r   <= 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        bomb_x_r[i] <= 10'd0;
        bomb_y_r[i] <= 10'd0;
      end
    end else if (arst) begin
      state_r       <= IDLE;
      col_r         <= 4'd0;
      scan_cnt_r    <= 4'd0;
      lfsr_r        <= 8'hA5;
      fire_cnt_r    <= FCW'(FIRE_PERIOD - 1);
      bomb_active_r <= '0;
      collision_r   <= 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        bomb_x_r[i] <= 10'd0;
        bomb_y_r[i] <= 10'd0;
      end
    end else begin
      state_r       <= state_s;
      col_r         <= col_s;
      scan_cnt_r    <= scan_cnt_s;
      lfsr_r        <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      bomb_active_r <= active_s;
      collision_r   <= hit_s;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        bomb_x_r[i] <= x_next_s[i];
        bomb_y_r[i] <= y_next_s[i];
      end
      if (bus.frame) begin
        fire_cnt_r <= (fire_cnt_r == '0) ? FCW'(FIRE_PERIOD - 1) : fire_cnt_r - FCW'(1);
      end else begin
        fire_cnt_r <= fire_cnt_r;
      end
    end
  end

  assign bus.bomb_active      = bomb_active_r;
  assign bus.player_collision = collision_r;

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_pack
    assign bus.bomb_x[10*g +: 10] = bomb_x_r[g];
    assign bus.bomb_y[10*g +: 10] = bomb_y_r[g];
  end
endmodule

// File: tb/tb_invader_bombs.sv
// Directed bench for invader_bombs; fire period shortened to 4 frames so several
// shots fit before a bomb can leave the screen.
module tb_invader_bombs;
  localparam int FP = 4;

  logic clk;
  logic rst;
  logic arst;
  int   vectors;
  int   miscompares;

  invader_bombs_if #(.NUM_BOMBS(3)) bus ();

  invader_bombs #(.NUM_BOMBS(3), .FIRE_PERIOD(FP)) dut (
    .clk  (clk),
    .rst  (rst),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_frame();
    @(negedge clk) bus.frame = 1'b1;
    @(negedge clk) bus.frame = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  task automatic do_arst();
    @(negedge clk) arst = 1'b1;
    @(negedge clk) arst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.bomb_active !== 3'b000) begin
      miscompares++; $display("FAIL reset_active: got %b expected 000", bus.bomb_active);
    end
    vectors++;
    if (bus.player_collision !== 1'b0) begin
      miscompares++; $display("FAIL reset_collision: got %b expected 0", bus.player_collision);
    end
    vectors++;
    if (bus.bomb_x !== 30'd0) begin
      miscompares++; $display("FAIL reset_x: got %h expected 0", bus.bomb_x);
    end
    vectors++;
    if (bus.bomb_y !== 30'd0) begin
      miscompares++; $display("FAIL reset_y: got %h expected 0", bus.bomb_y);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_column_fallback();
    bus.invaders   = 55'd1 << 54;
    bus.invaders_x = 10'd100;
    bus.invaders_y = 10'd50;
    bus.player_x   = 10'd0;
    bus.player_y   = 10'd0;
    do_arst();
    repeat (FP - 1) do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b000) begin
      miscompares++; $display("FAIL fallback_early: got %b expected 000", bus.bomb_active);
    end
    do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b001) begin
      miscompares++; $display("FAIL fallback_active: got %b expected 001", bus.bomb_active);
    end
    vectors++;
    if (bus.bomb_x[9:0] !== 10'd431) begin
      miscompares++; $display("FAIL fallback_x: got %0d expected 431", bus.bomb_x[9:0]);
    end
    vectors++;
    if (bus.bomb_y[9:0] !== 10'd162) begin
      miscompares++; $display("FAIL fallback_y: got %0d expected 162", bus.bomb_y[9:0]);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_arst();
    repeat (FP - 1) do_frame();
    @(negedge clk) bus.frame = 1'b1;
    @(negedge clk) begin
      bus.frame = 1'b0;
      rst       = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if (bus.bomb_active !== 3'b000 || bus.player_collision !== 1'b0) begin
      miscompares++;
      $display("FAIL midscan_reset: got act=%b col=%b expected 000/0", bus.bomb_active, bus.player_collision);
    end
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.bomb_active !== 3'b000) begin
      miscompares++; $display("FAIL midscan_nospawn: got %b expected 000", bus.bomb_active);
    end
    repeat (FP - 1) do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b000) begin
      miscompares++; $display("FAIL midscan_early: got %b expected 000", bus.bomb_active);
    end
    do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b001 || bus.bomb_y[9:0] !== 10'd162) begin
      miscompares++;
      $display("FAIL midscan_first_fire: got act=%b y=%0d expected 001/162", bus.bomb_active, bus.bomb_y[9:0]);
    end
  endtask

  task automatic test_empty_formation();
    bus.invaders = 55'd0;
    do_arst();
    for (int f = 0; f < 200; f++) begin
      do_frame();
      vectors++;
      if (bus.bomb_active !== 3'b000) begin
        miscompares++; $display("FAIL empty_frame%0d: got %b expected 000", f, bus.bomb_active);
      end
    end
  endtask

  task automatic test_saturation();
    bus.invaders   = 55'd1 << 54;
    bus.invaders_x = 10'd100;
    bus.invaders_y = 10'd50;
    bus.player_x   = 10'd0;
    bus.player_y   = 10'd0;
    do_arst();
    repeat (4 * FP) do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b111) begin
      miscompares++; $display("FAIL sat_active: got %b expected 111", bus.bomb_active);
    end
    vectors++;
    if (bus.bomb_y !== {10'd178, 10'd194, 10'd210}) begin
      miscompares++;
      $display("FAIL sat_y: got %0d,%0d,%0d expected 210,194,178",
               bus.bomb_y[9:0], bus.bomb_y[19:10], bus.bomb_y[29:20]);
    end
    vectors++;
    if (bus.bomb_x !== {10'd431, 10'd431, 10'd431}) begin
      miscompares++; $display("FAIL sat_x: got %h expected all 431", bus.bomb_x);
    end
  endtask

  task automatic test_multi_hit();
    bus.invaders   = 55'd1;
    bus.invaders_x = 10'd289;
    bus.invaders_y = 10'd400;
    bus.player_x   = 10'd300;
    bus.player_y   = 10'd440;
    do_arst();
    repeat (FP) do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b001 || bus.bomb_x[9:0] !== 10'd300 || bus.bomb_y[9:0] !== 10'd416) begin
      miscompares++;
      $display("FAIL hit_first: got act=%b x=%0d y=%0d expected 001/300/416",
               bus.bomb_active, bus.bomb_x[9:0], bus.bomb_y[9:0]);
    end
    bus.invaders_y = 10'd416;
    repeat (FP) do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b011 || bus.bomb_y[19:0] !== {10'd432, 10'd432}) begin
      miscompares++;
      $display("FAIL hit_touching: got act=%b y0=%0d y1=%0d expected 011/432/432",
               bus.bomb_active, bus.bomb_y[9:0], bus.bomb_y[19:10]);
    end
    bus.invaders = 55'd0;
    @(negedge clk) bus.frame = 1'b1;
    @(negedge clk) bus.frame = 1'b0;
    vectors++;
    if (bus.player_collision !== 1'b1 || bus.bomb_active !== 3'b000) begin
      miscompares++;
      $display("FAIL hit_pulse: got col=%b act=%b expected 1/000", bus.player_collision, bus.bomb_active);
    end
    @(negedge clk);
    vectors++;
    if (bus.player_collision !== 1'b0) begin
      miscompares++; $display("FAIL hit_one_cycle: got %b expected 0", bus.player_collision);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_screen_exit();
    bus.invaders   = 55'd1;
    bus.invaders_x = 10'd0;
    bus.invaders_y = 10'd452;
    bus.player_x   = 10'd300;
    bus.player_y   = 10'd440;
    do_arst();
    repeat (FP) do_frame();
    vectors++;
    if (bus.bomb_active !== 3'b001 || bus.bomb_x[9:0] !== 10'd11 || bus.bomb_y[9:0] !== 10'd468) begin
      miscompares++;
      $display("FAIL exit_spawn: got act=%b x=%0d y=%0d expected 001/11/468",
               bus.bomb_active, bus.bomb_x[9:0], bus.bomb_y[9:0]);
    end
    @(negedge clk) bus.frame = 1'b1;
    @(negedge clk) bus.frame = 1'b0;
    vectors++;
    if (bus.bomb_active !== 3'b001 || bus.bomb_y[9:0] !== 10'd472 || bus.player_collision !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_limit: got act=%b y=%0d col=%b expected 001/472/0",
               bus.bomb_active, bus.bomb_y[9:0], bus.player_collision);
    end
    repeat (22) @(negedge clk);
    @(negedge clk) bus.frame = 1'b1;
    @(negedge clk) bus.frame = 1'b0;
    vectors++;
    if (bus.bomb_active !== 3'b000 || bus.player_collision !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_cleared: got act=%b col=%b expected 000/0", bus.bomb_active, bus.player_collision);
    end
    repeat (22) @(negedge clk);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b0;
    arst           = 1'b0;
    bus.frame      = 1'b0;
    bus.invaders   = 55'd0;
    bus.invaders_x = 10'd0;
    bus.invaders_y = 10'd0;
    bus.player_x   = 10'd0;
    bus.player_y   = 10'd0;
    test_reset();
    test_column_fallback();
    test_reset_mid_scan();
    test_empty_formation();
    test_saturation();
    test_multi_hit();
    test_screen_exit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
